game_countdown_timer: RTL and testbench

//  Counts a game round down from a loadable M:SS preset to 0:00, one step per second.

---
 rtl/game_countdown_timer_pkg.sv | 79 +++++++
 rtl/game_countdown_timer_sec_tick_gen.sv | 31 +++
 rtl/game_countdown_timer.sv | 115 +++++++++++
 tb/tb_game_countdown_timer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_countdown_timer_pkg.sv
// Shared types, segment patterns and BCD helpers
// for the round countdown timer.
package game_countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUNNING,
    ST_PAUSED,
    ST_EXPIRED
  } state_t;

  localparam logic [3:0] MIN_MAX   = 4'd9;
  localparam logic [3:0] SEC_T_MAX = 4'd5;
  localparam logic [3:0] SEC_U_MAX = 4'd9;

  localparam logic [11:0] BCD_ZERO = 12'h000;
  localparam logic [11:0] BCD_LAST = 12'h001;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg7(
    input logic [3:0] d
  );
    case (d)
      4'd0:    seg7 = SEG_0;
      4'd1:    seg7 = SEG_1;
      4'd2:    seg7 = SEG_2;
      4'd3:    seg7 = SEG_3;
      4'd4:    seg7 = SEG_4;
      4'd5:    seg7 = SEG_5;
      4'd6:    seg7 = SEG_6;
      4'd7:    seg7 = SEG_7;
      4'd8:    seg7 = SEG_8;
      4'd9:    seg7 = SEG_9;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  function automatic logic bcd_valid(
    input logic [11:0] v
  );
    bcd_valid = (v[11:8] <= MIN_MAX)
             && (v[7:4] <= SEC_T_MAX)
             && (v[3:0] <= SEC_U_MAX);
  endfunction

  // Callers guarantee v != 0:00, so the minute never wraps.
  function automatic logic [11:0] bcd_dec(
    input logic [11:0] v
  );
    logic [3:0] m, t, u;
    m = v[11:8];
    t = v[7:4];
    u = v[3:0];
    if (u != 4'd0) begin
      u = u - 4'd1;
    end else begin
      u = SEC_U_MAX;
      if (t != 4'd0) begin
        t = t - 4'd1;
      end else begin
        t = SEC_T_MAX;
        m = m - 4'd1;
      end
    end
    bcd_dec = {m, t, u};
  endfunction

endpackage

// File: rtl/game_countdown_timer_sec_tick_gen.sv
// One-second tick divider; phase is held whenever
// run is low and restarted on round entry or abort.
module sec_tick_gen #(
  parameter int TICK_CYCLES = 50_000_000
) (
  input  logic Clck,
  input  logic reset,
  input  logic run,
  input  logic restart,
  output logic tick
);

  localparam int W =
    (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [W-1:0] MAX = W'(TICK_CYCLES - 1);

  logic [W-1:0] cnt;

  assign tick = run && (cnt == '0);

  always_ff @(posedge Clck) begin
    if (reset) begin
      cnt <= MAX;
    end else if (restart) begin
      cnt <= MAX;
    end else if (run) begin
      cnt <= (cnt == '0) ? MAX : cnt - 1'b1;
    end
  end

endmodule

// File: rtl/game_countdown_timer.sv
// M:SS round countdown with pause/stop control,
// preset capture and active-low 7-seg outputs.
module game_countdown_timer
  import game_countdown_timer_pkg::*;
#(
  parameter int          TICK_CYCLES = 50_000_000,
  parameter logic [11:0] DEF_PRESET  = 12'h100
) (
  input  logic        Clck,
  input  logic        reset,
  input  logic        game_start,
  input  logic        pause,
  input  logic        stop,
  input  logic        preset_load,
  input  logic [11:0] preset_bcd,
  output logic [11:0] digits,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic        running,
  output logic        expired,
  output logic        time_up,
  output logic        preset_err
);

  state_t      state;
  logic [11:0] preset;
  logic [11:0] new_preset;
  logic        ready;
  logic        load_ok;
  logic        start_ok;
  logic        run;
  logic        restart;
  logic        tick;

  assign ready    = (state == ST_IDLE)
                 || (state == ST_EXPIRED);
  assign load_ok  = preset_load && ready
                 && bcd_valid(preset_bcd);
  assign new_preset = load_ok ? preset_bcd : preset;
  assign start_ok = game_start && !stop && ready;

  // Counting continues in the very cycle pause drops,
  // so a pause of N cycles delays the tick by exactly N.
  assign run = ((state == ST_RUNNING)
             || (state == ST_PAUSED))
            && !pause && !stop;
  assign restart = stop || start_ok;

  sec_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick (
    .Clck   (Clck),
    .reset  (reset),
    .run    (run),
    .restart(restart),
    .tick   (tick)
  );

  assign running = (state == ST_RUNNING);
  assign expired = (state == ST_EXPIRED);

  always_ff @(posedge Clck) begin
    if (reset) begin
      state      <= ST_IDLE;
      preset     <= DEF_PRESET;
      digits     <= DEF_PRESET;
      time_up    <= 1'b0;
      preset_err <= 1'b0;
    end else begin
      time_up    <= 1'b0;
      preset_err <= preset_load && !load_ok;
      preset     <= new_preset;
      if (stop) begin
        state  <= ST_IDLE;
        digits <= new_preset;
      end else begin
        unique case (state)
          ST_IDLE, ST_EXPIRED: begin
            if (game_start) begin
              if (preset == BCD_ZERO) begin
                state   <= ST_EXPIRED;
                digits  <= BCD_ZERO;
                time_up <= 1'b1;
              end else begin
                state  <= ST_RUNNING;
                digits <= preset;
              end
            end else if (state == ST_IDLE && load_ok) begin
              digits <= preset_bcd;
            end
          end
          ST_RUNNING, ST_PAUSED: begin
            if (pause) begin
              state <= ST_PAUSED;
            end else if (tick && digits == BCD_LAST) begin
              state   <= ST_EXPIRED;
              digits  <= BCD_ZERO;
              time_up <= 1'b1;
            end else begin
              state <= ST_RUNNING;
              if (tick) digits <= bcd_dec(digits);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign HEX0 = seg7(digits[3:0]);
  assign HEX1 = seg7(digits[7:4]);
  assign HEX2 = seg7(digits[11:8]);

endmodule

// File: tb/tb_game_countdown_timer.sv
// Directed bench for the countdown timer with a
// four-cycle second; expectations are hand-derived.
module tb_game_countdown_timer;

  logic        Clck;
  logic        reset;
  logic        game_start;
  logic        pause;
  logic        stop;
  logic        preset_load;
  logic [11:0] preset_bcd;
  logic [11:0] digits;
  logic [6:0]  HEX0, HEX1, HEX2;
  logic        running;
  logic        expired;
  logic        time_up;
  logic        preset_err;

  int n_tests = 0;
  int n_fail  = 0;
  int up_cnt  = 0;
  int err_cnt = 0;

  game_countdown_timer #(
    .TICK_CYCLES(4),
    .DEF_PRESET (12'h100)
  ) dut (
    .Clck       (Clck),
    .reset      (reset),
    .game_start (game_start),
    .pause      (pause),
    .stop       (stop),
    .preset_load(preset_load),
    .preset_bcd (preset_bcd),
    .digits     (digits),
    .HEX0       (HEX0),
    .HEX1       (HEX1),
    .HEX2       (HEX2),
    .running    (running),
    .expired    (expired),
    .time_up    (time_up),
    .preset_err (preset_err)
  );

  initial begin
    Clck = 1'b0;
    forever #5 Clck = ~Clck;
  end

  task automatic check(
    input string       tag,
    input logic [11:0] got,
    input logic [11:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clck);
      #1;
      if (time_up)    up_cnt++;
      if (preset_err) err_cnt++;
    end
  endtask

  initial begin
    reset       = 1'b1;
    game_start  = 1'b0;
    pause       = 1'b0;
    stop        = 1'b0;
    preset_load = 1'b0;
    preset_bcd  = 12'h000;
    step(2);
    reset = 1'b0;
    up_cnt  = 0;
    err_cnt = 0;

    // reset and idle
    step(10);
    check("rst_digits", digits, 12'h100);
    check("rst_hex2", 12'(HEX2), 12'(7'b1111001));
    check("rst_hex1", 12'(HEX1), 12'(7'b1000000));
    check("rst_hex0", 12'(HEX0), 12'(7'b1000000));
    check("rst_running", 12'(running), 12'h0);
    check("rst_expired", 12'(expired), 12'h0);
    check("idle_pulses", 12'(up_cnt + err_cnt), 12'h0);

    // 0:12 round to expiry
    preset_load = 1'b1;
    preset_bcd  = 12'h012;
    step(1);
    preset_load = 1'b0;
    check("idle_follow", digits, 12'h012);
    game_start = 1'b1;
    step(1);
    game_start = 1'b0;
    check("start_run", 12'(running), 12'h1);
    check("start_digits", digits, 12'h012);
    step(3);
    check("pre_tick", digits, 12'h012);
    step(1);
    check("first_tick", digits, 12'h011);
    step(43);
    check("at_0_01", digits, 12'h001);
    check("no_early_up", 12'(up_cnt), 12'h0);
    step(1);
    check("zero_digits", digits, 12'h000);
    check("zero_time_up", 12'(time_up), 12'h1);
    check("zero_expired", 12'(expired), 12'h1);
    step(3);
    check("up_once", 12'(up_cnt), 12'h1);
    check("up_low", 12'(time_up), 12'h0);
    check("exp_hold", digits, 12'h000);

    // 1:00 borrow chain, load in EXPIRED
    preset_load = 1'b1;
    preset_bcd  = 12'h100;
    step(1);
    preset_load = 1'b0;
    check("exp_load_dig", digits, 12'h000);
    check("exp_load_err", 12'(preset_err), 12'h0);
    game_start = 1'b1;
    step(1);
    game_start = 1'b0;
    check("restart_dig", digits, 12'h100);
    step(4);
    check("borrow_059", digits, 12'h059);
    step(4);
    check("dec_058", digits, 12'h058);
    check("hex0_8", 12'(HEX0), 12'(7'b0000000));
    check("hex1_5", 12'(HEX1), 12'(7'b0010010));
    check("hex2_0", 12'(HEX2), 12'(7'b1000000));

    // pause mid-tick
    step(2);
    pause = 1'b1;
    step(10);
    check("pause_dig", digits, 12'h058);
    check("pause_run", 12'(running), 12'h0);
    pause = 1'b0;
    step(1);
    check("resume_dig", digits, 12'h058);
    check("resume_run", 12'(running), 12'h1);
    step(1);
    check("resume_tick", digits, 12'h057);

    // rejected loads
    err_cnt = 0;
    preset_load = 1'b1;
    preset_bcd  = 12'h050;
    step(1);
    preset_load = 1'b0;
    check("run_load_err", 12'(preset_err), 12'h1);
    step(1);
    check("err_pulse", 12'(preset_err), 12'h0);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    check("stop_dig", digits, 12'h100);
    check("stop_run", 12'(running), 12'h0);
    preset_load = 1'b1;
    preset_bcd  = 12'h070;
    step(1);
    preset_load = 1'b0;
    check("bad_bcd_err", 12'(preset_err), 12'h1);
    check("bad_bcd_dig", digits, 12'h100);
    check("err_count", 12'(err_cnt), 12'h2);

    // stop beats game_start
    stop       = 1'b1;
    game_start = 1'b1;
    step(1);
    stop       = 1'b0;
    game_start = 1'b0;
    check("stop_win_run", 12'(running), 12'h0);
    step(5);
    check("stop_win_dig", digits, 12'h100);

    // reset mid-round
    game_start = 1'b1;
    step(1);
    game_start = 1'b0;
    step(6);
    check("mid_dig", digits, 12'h059);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("mid_rst_dig", digits, 12'h100);
    check("mid_rst_run", 12'(running), 12'h0);
    check("mid_rst_exp", 12'(expired), 12'h0);
    check("mid_rst_up", 12'(time_up), 12'h0);
    check("mid_rst_hex2", 12'(HEX2), 12'(7'b1111001));

    // zero preset start
    preset_load = 1'b1;
    preset_bcd  = 12'h000;
    step(1);
    preset_load = 1'b0;
    check("zload_dig", digits, 12'h000);
    game_start = 1'b1;
    step(1);
    game_start = 1'b0;
    check("zstart_exp", 12'(expired), 12'h1);
    check("zstart_up", 12'(time_up), 12'h1);
    step(1);
    check("zstart_up_lo", 12'(time_up), 12'h0);

    // load and start together: old preset used
    preset_load = 1'b1;
    preset_bcd  = 12'h003;
    game_start  = 1'b1;
    step(1);
    preset_load = 1'b0;
    game_start  = 1'b0;
    check("ls_old_up", 12'(time_up), 12'h1);
    check("ls_old_exp", 12'(expired), 12'h1);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    check("ls_new_dig", digits, 12'h003);
    check("ls_idle", 12'(expired), 12'h0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
